// File: rtl/saph_fpu_client_pkg.sv
// Shared types for the shader-lane FPU client: op encoding, completion-slot
// states and the slot record layout.
package saph_fpu_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        MUL = 2'd1,
        DIV = 2'd2,
        RSV = 2'd3
    } fpu_op_t;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } slot_state_t;

    // Default field widths of one completion slot (binary32 result, 32 registers).
    localparam int SLOT_RD_W   = 5;
    localparam int SLOT_DATA_W = 32;

    typedef struct packed {
        slot_state_t              state;
        logic [SLOT_RD_W-1:0]     rd;
        logic [SLOT_DATA_W-1:0]   data;
    } slot_t;

endpackage

// File: rtl/saph_fpu_client_if.sv
// Bundle of the lane issue port, the FPU request/response port and the
// register-file write-back port. The client uses the slave view; the lane,
// FPU and register file together form the master view.
interface saph_fpu_client_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int TAG_W  = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [RD_W-1:0]   in_rd;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [TAG_W-1:0]  req_tag;

    logic              resp_valid;
    logic [TAG_W-1:0]  resp_tag;
    logic [DATA_W-1:0] resp_data;

    logic              wb_valid;
    logic              wb_ready;
    logic [RD_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_data;

    modport slave (
        input  in_valid, in_op, in_rd, in_a, in_b,
        output in_ready,
        output req_valid, req_op, req_a, req_b, req_tag,
        input  req_ready,
        input  resp_valid, resp_tag, resp_data,
        output wb_valid, wb_rd, wb_data,
        input  wb_ready
    );

    modport master (
        output in_valid, in_op, in_rd, in_a, in_b,
        input  in_ready,
        input  req_valid, req_op, req_a, req_b, req_tag,
        output req_ready,
        output resp_valid, resp_tag, resp_data,
        input  wb_valid, wb_rd, wb_data,
        output wb_ready
    );

endinterface

// File: rtl/saph_fpu_client_rob.sv
// Completion buffer: slots allocated in program order at tail, filled by
// out-of-order FPU responses, retired in order from head.
module saph_fpu_client_rob
    import saph_fpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = $clog2(DEPTH),
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc,
    input  logic [RD_W-1:0]   alloc_rd,
    input  logic              resp_valid,
    input  logic [TAG_W-1:0]  resp_tag,
    input  logic [DATA_W-1:0] resp_data,
    input  logic              wb_ready,
    output logic [TAG_W-1:0]  tail,
    output logic [TAG_W:0]    count,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              stray,
    output logic              busy
);

    slot_state_t       state_q [DEPTH];
    logic [RD_W-1:0]   rd_q    [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [TAG_W-1:0]  head;
    logic              resp_hit;
    logic              retire;

    // A response only lands on a slot that is waiting for it; anything else is stray.
    assign resp_hit = resp_valid && (state_q[resp_tag] == WAIT);
    assign stray    = resp_valid && !resp_hit;

    // Head slot drives write-back from registers only.
    assign wb_valid = (state_q[head] == DONE);
    assign wb_rd    = rd_q[head];
    assign wb_data  = data_q[head];
    assign retire   = wb_valid && wb_ready;
    assign busy     = (count != '0);

    // Slot state machine per entry plus the in-order pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) state_q[i] <= FREE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc && (tail == TAG_W'(i)))
                    state_q[i] <= WAIT;
                else if (resp_hit && (resp_tag == TAG_W'(i)))
                    state_q[i] <= DONE;
                else if (retire && (head == TAG_W'(i)))
                    state_q[i] <= FREE;
            end
            if (alloc)  tail <= tail + TAG_W'(1);
            if (retire) head <= head + TAG_W'(1);
            if (alloc && !retire)
                count <= count + (TAG_W+1)'(1);
            else if (!alloc && retire)
                count <= count - (TAG_W+1)'(1);
        end
    end

    // Slot payload: destination captured on allocation, result on response.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc && (tail == TAG_W'(i)))
                rd_q[i] <= alloc_rd;
            if (resp_hit && (resp_tag == TAG_W'(i)))
                data_q[i] <= resp_data;
        end
    end

endmodule

// File: rtl/saph_fpu_client.sv
// Per-lane FPU requester: accepts ops from issue, tags them with a
// completion slot, drives the FPU request register and retires results
// to the register file in program order.
module saph_fpu_client
    import saph_fpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = $clog2(DEPTH),
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    saph_fpu_client_if.slave    bus,
    output logic                busy,
    output logic                err
);

    localparam logic [TAG_W:0] CAP = (TAG_W+1)'(DEPTH);

    logic [TAG_W:0]   count;
    logic [TAG_W-1:0] tail;
    logic             accept;
    logic             rsv_seen;
    logic             stray;
    logic             rob_busy;

    // Reserved ops are never accepted; full is decided by occupancy only,
    // so a retire in the same cycle does not open a slot early.
    assign rsv_seen     = bus.in_valid && (fpu_op_t'(bus.in_op) == RSV);
    assign bus.in_ready = (count < CAP) && (!bus.req_valid || bus.req_ready)
                          && (fpu_op_t'(bus.in_op) != RSV);
    assign accept       = bus.in_valid && bus.in_ready;
    assign busy         = rob_busy || bus.req_valid;

    // Request valid: set on accept, held under backpressure, cleared on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bus.req_valid <= 1'b0;
        else if (accept)
            bus.req_valid <= 1'b1;
        else if (bus.req_ready)
            bus.req_valid <= 1'b0;
    end

    // Request payload loads only on accept, so it stays stable while stalled.
    always_ff @(posedge clk) begin
        if (accept) begin
            bus.req_op  <= bus.in_op;
            bus.req_a   <= bus.in_a;
            bus.req_b   <= bus.in_b;
            bus.req_tag <= tail;
        end
    end

    // Sticky protocol error: reserved op presented or response to a non-waiting slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err <= 1'b0;
        else if (rsv_seen || stray)
            err <= 1'b1;
    end

    saph_fpu_client_rob #(
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_rob (
        .clk        (clk),
        .rst        (rst),
        .alloc      (accept),
        .alloc_rd   (bus.in_rd),
        .resp_valid (bus.resp_valid),
        .resp_tag   (bus.resp_tag),
        .resp_data  (bus.resp_data),
        .wb_ready   (bus.wb_ready),
        .tail       (tail),
        .count      (count),
        .wb_valid   (bus.wb_valid),
        .wb_rd      (bus.wb_rd),
        .wb_data    (bus.wb_data),
        .stray      (stray),
        .busy       (rob_busy)
    );

endmodule

// File: tb/tb_saph_fpu_client.sv
// Testbench for saph_fpu_client: directed scenarios plus a randomized run
// against an in-order queue model of the client.
module tb_saph_fpu_client;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 2;
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic err;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    saph_fpu_client_if #(.DATA_W(DATA_W), .RD_W(RD_W), .TAG_W(TAG_W)) bus ();

    saph_fpu_client #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    typedef struct {
        int                tag;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
        bit                done;
    } ent_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.in_op      = 2'd0;
        bus.in_rd      = '0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_tag   = '0;
        bus.resp_data  = '0;
        bus.wb_ready   = 1'b0;
    endtask

    task automatic drive_op(input logic [1:0] op, input logic [RD_W-1:0] rd,
                            input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    task automatic drop_op();
        bus.in_valid = 1'b0;
        bus.in_op    = 2'd0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
        n_cmp++; if (bus.req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid got %0b want 0", bus.req_valid); end
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wb_valid got %0b want 0", bus.wb_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0b want 0", err); end
    endtask

    task automatic test_single();
        do_reset();
        bus.req_ready = 1'b1;
        drive_op(2'd0, 5'd3, 32'h3F800000, 32'h40000000);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL single_in_ready got %0b want 1", bus.in_ready); end
        tick();
        drop_op();
        n_cmp++; if (bus.req_valid !== 1'b1) begin n_bad++; $display("FAIL single_req_valid got %0b want 1", bus.req_valid); end
        n_cmp++; if (bus.req_tag !== 2'd0) begin n_bad++; $display("FAIL single_req_tag got %0d want 0", bus.req_tag); end
        n_cmp++; if (bus.req_op !== 2'd0) begin n_bad++; $display("FAIL single_req_op got %0d want 0", bus.req_op); end
        n_cmp++; if (bus.req_a !== 32'h3F800000) begin n_bad++; $display("FAIL single_req_a got %h want 3f800000", bus.req_a); end
        n_cmp++; if (bus.req_b !== 32'h40000000) begin n_bad++; $display("FAIL single_req_b got %h want 40000000", bus.req_b); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_inflight got %0b want 1", busy); end
        tick();
        n_cmp++; if (bus.req_valid !== 1'b0) begin n_bad++; $display("FAIL single_req_clear got %0b want 0", bus.req_valid); end
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL single_wb_early got %0b want 0", bus.wb_valid); end
        bus.resp_valid = 1'b1; bus.resp_tag = 2'd0; bus.resp_data = 32'h40400000;
        tick();
        bus.resp_valid = 1'b0;
        n_cmp++; if (bus.wb_valid !== 1'b1) begin n_bad++; $display("FAIL single_wb_valid got %0b want 1", bus.wb_valid); end
        n_cmp++; if (bus.wb_rd !== 5'd3) begin n_bad++; $display("FAIL single_wb_rd got %0d want 3", bus.wb_rd); end
        n_cmp++; if (bus.wb_data !== 32'h40400000) begin n_bad++; $display("FAIL single_wb_data got %h want 40400000", bus.wb_data); end
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL single_wb_after got %0b want 0", bus.wb_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_after got %0b want 0", busy); end
    endtask

    task automatic test_out_of_order();
        logic [DATA_W-1:0] d0, d1;
        d0 = $urandom; d1 = $urandom;
        do_reset();
        bus.req_ready = 1'b1;
        drive_op(2'd2, 5'd1, $urandom, $urandom);
        tick();
        n_cmp++; if (bus.req_tag !== 2'd0) begin n_bad++; $display("FAIL ooo_tag0 got %0d want 0", bus.req_tag); end
        n_cmp++; if (bus.req_op !== 2'd2) begin n_bad++; $display("FAIL ooo_op_div got %0d want 2", bus.req_op); end
        drive_op(2'd0, 5'd2, $urandom, $urandom);
        tick();
        drop_op();
        n_cmp++; if (bus.req_tag !== 2'd1) begin n_bad++; $display("FAIL ooo_tag1 got %0d want 1", bus.req_tag); end
        n_cmp++; if (bus.req_op !== 2'd0) begin n_bad++; $display("FAIL ooo_op_add got %0d want 0", bus.req_op); end
        tick();
        bus.resp_valid = 1'b1; bus.resp_tag = 2'd1; bus.resp_data = d1;
        tick();
        bus.resp_valid = 1'b0;
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL ooo_hold_0 got %0b want 0", bus.wb_valid); end
        for (int k = 1; k < 5; k++) begin
            tick();
            n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL ooo_hold_%0d got %0b want 0", k, bus.wb_valid); end
        end
        bus.resp_valid = 1'b1; bus.resp_tag = 2'd0; bus.resp_data = d0;
        tick();
        bus.resp_valid = 1'b0;
        n_cmp++; if (bus.wb_valid !== 1'b1) begin n_bad++; $display("FAIL ooo_wb0_valid got %0b want 1", bus.wb_valid); end
        n_cmp++; if (bus.wb_rd !== 5'd1) begin n_bad++; $display("FAIL ooo_wb0_rd got %0d want 1", bus.wb_rd); end
        n_cmp++; if (bus.wb_data !== d0) begin n_bad++; $display("FAIL ooo_wb0_data got %h want %h", bus.wb_data, d0); end
        bus.wb_ready = 1'b1;
        tick();
        n_cmp++; if (bus.wb_valid !== 1'b1) begin n_bad++; $display("FAIL ooo_wb1_valid got %0b want 1", bus.wb_valid); end
        n_cmp++; if (bus.wb_rd !== 5'd2) begin n_bad++; $display("FAIL ooo_wb1_rd got %0d want 2", bus.wb_rd); end
        n_cmp++; if (bus.wb_data !== d1) begin n_bad++; $display("FAIL ooo_wb1_data got %h want %h", bus.wb_data, d1); end
        tick();
        bus.wb_ready = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ooo_busy_end got %0b want 0", busy); end
    endtask

    task automatic test_full();
        do_reset();
        bus.req_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            drive_op(2'd1, RD_W'(10 + k), DATA_W'(k), 32'h0);
            #1;
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL full_fill_%0d got %0b want 1", k, bus.in_ready); end
            tick();
        end
        drive_op(2'd0, 5'd20, 32'h00000055, 32'h0);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got %0b want 0", bus.in_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_hold_%0d got %0b want 0", k, bus.in_ready); end
        end
        n_cmp++; if (bus.req_valid !== 1'b0) begin n_bad++; $display("FAIL full_no_accept got %0b want 0", bus.req_valid); end
        bus.resp_valid = 1'b1; bus.resp_tag = 2'd0; bus.resp_data = 32'hABCD0000;
        tick();
        bus.resp_valid = 1'b0;
        bus.wb_ready = 1'b1;
        #1;
        n_cmp++; if (bus.wb_valid !== 1'b1) begin n_bad++; $display("FAIL full_wb_valid got %0b want 1", bus.wb_valid); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_no_bypass got %0b want 0", bus.in_ready); end
        tick();
        bus.wb_ready = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL full_after_retire got %0b want 1", bus.in_ready); end
        tick();
        drop_op();
        n_cmp++; if (bus.req_valid !== 1'b1) begin n_bad++; $display("FAIL full_wrap_valid got %0b want 1", bus.req_valid); end
        n_cmp++; if (bus.req_tag !== 2'd0) begin n_bad++; $display("FAIL full_wrap_tag got %0d want 0", bus.req_tag); end
        n_cmp++; if (bus.req_a !== 32'h00000055) begin n_bad++; $display("FAIL full_wrap_a got %h want 00000055", bus.req_a); end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] a1, b1, a2, b2, d1, d2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom; d1 = $urandom; d2 = $urandom;
        do_reset();
        drive_op(2'd1, 5'd4, a1, b1);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_first_ready got %0b want 1", bus.in_ready); end
        tick();
        drive_op(2'd2, 5'd5, a2, b2);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stall_ready_%0d got %0b want 0", k, bus.in_ready); end
            n_cmp++; if (bus.req_valid !== 1'b1 || bus.req_op !== 2'd1 || bus.req_tag !== 2'd0)
                begin n_bad++; $display("FAIL bp_stall_req_%0d got v%0b op%0d tag%0d want v1 op1 tag0", k, bus.req_valid, bus.req_op, bus.req_tag); end
            n_cmp++; if (bus.req_a !== a1 || bus.req_b !== b1)
                begin n_bad++; $display("FAIL bp_stall_data_%0d got %h/%h want %h/%h", k, bus.req_a, bus.req_b, a1, b1); end
            tick();
        end
        bus.req_ready = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %0b want 1", bus.in_ready); end
        tick();
        drop_op();
        n_cmp++; if (bus.req_valid !== 1'b1 || bus.req_tag !== 2'd1 || bus.req_op !== 2'd2 || bus.req_a !== a2)
            begin n_bad++; $display("FAIL bp_refill got v%0b tag%0d op%0d a%h want v1 tag1 op2 a%h", bus.req_valid, bus.req_tag, bus.req_op, bus.req_a, a2); end
        tick();
        n_cmp++; if (bus.req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got %0b want 0", bus.req_valid); end
        bus.resp_valid = 1'b1; bus.resp_tag = 2'd1; bus.resp_data = d2;
        tick();
        bus.resp_tag = 2'd0; bus.resp_data = d1;
        tick();
        bus.resp_valid = 1'b0;
        n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd4 || bus.wb_data !== d1)
            begin n_bad++; $display("FAIL bp_wb0 got v%0b rd%0d d%h want v1 rd4 d%h", bus.wb_valid, bus.wb_rd, bus.wb_data, d1); end
        bus.wb_ready = 1'b1;
        tick();
        n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd5 || bus.wb_data !== d2)
            begin n_bad++; $display("FAIL bp_wb1 got v%0b rd%0d d%h want v1 rd5 d%h", bus.wb_valid, bus.wb_rd, bus.wb_data, d2); end
        tick();
        bus.wb_ready = 1'b0;
        n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL bp_no_leak got busy%0b err%0b want 0 0", busy, err); end
    endtask

    task automatic test_random();
        ent_t              pend[$];
        int                elig[$];
        bit                m_rv = 0;
        int                m_tag = 0;
        logic [1:0]        m_op = '0;
        logic [DATA_W-1:0] m_a = '0;
        int                next_tag = 0;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit                v, rr, wr, rv, exp_ready, exp_wbv, acc, hs, ret;
            int                rtag, hs_tag;
            logic [1:0]        op;
            logic [RD_W-1:0]   rd;
            logic [DATA_W-1:0] a, b, rdata;
            v  = ($urandom_range(0, 99) < 60);
            op = 2'($urandom_range(0, 2));
            rd = RD_W'($urandom);
            a  = $urandom;
            b  = $urandom;
            rr = ($urandom_range(0, 99) < 70);
            wr = ($urandom_range(0, 99) < 70);
            rv = 0; rtag = 0; rdata = $urandom;
            if (elig.size() > 0 && $urandom_range(0, 99) < 50) begin
                int idx;
                idx  = $urandom_range(0, elig.size() - 1);
                rtag = elig[idx];
                elig.delete(idx);
                rv   = 1;
            end
            bus.in_valid = v; bus.in_op = op; bus.in_rd = rd; bus.in_a = a; bus.in_b = b;
            bus.req_ready = rr; bus.wb_ready = wr;
            bus.resp_valid = rv; bus.resp_tag = TAG_W'(rtag); bus.resp_data = rdata;
            #1;
            exp_ready = (pend.size() < DEPTH) && (!m_rv || rr);
            exp_wbv   = (pend.size() > 0) && pend[0].done;
            n_cmp++; if (bus.in_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_in_ready cyc%0d got %0b want %0b", cyc, bus.in_ready, exp_ready); end
            n_cmp++; if (bus.req_valid !== m_rv) begin n_bad++; $display("FAIL rnd_req_valid cyc%0d got %0b want %0b", cyc, bus.req_valid, m_rv); end
            if (m_rv) begin
                n_cmp++; if (bus.req_tag !== TAG_W'(m_tag) || bus.req_op !== m_op || bus.req_a !== m_a)
                    begin n_bad++; $display("FAIL rnd_req cyc%0d got tag%0d op%0d a%h want tag%0d op%0d a%h", cyc, bus.req_tag, bus.req_op, bus.req_a, m_tag, m_op, m_a); end
            end
            n_cmp++; if (bus.wb_valid !== exp_wbv) begin n_bad++; $display("FAIL rnd_wb_valid cyc%0d got %0b want %0b", cyc, bus.wb_valid, exp_wbv); end
            if (exp_wbv) begin
                n_cmp++; if (bus.wb_rd !== pend[0].rd || bus.wb_data !== pend[0].data)
                    begin n_bad++; $display("FAIL rnd_wb cyc%0d got rd%0d d%h want rd%0d d%h", cyc, bus.wb_rd, bus.wb_data, pend[0].rd, pend[0].data); end
            end
            n_cmp++; if (busy !== ((pend.size() > 0) || m_rv)) begin n_bad++; $display("FAIL rnd_busy cyc%0d got %0b", cyc, busy); end
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rnd_err cyc%0d got %0b want 0", cyc, err); end
            acc = v && exp_ready;
            hs  = m_rv && rr;
            ret = exp_wbv && wr;
            hs_tag = m_tag;
            if (rv) begin
                foreach (pend[i]) if (pend[i].tag == rtag && !pend[i].done) begin
                    pend[i].done = 1;
                    pend[i].data = rdata;
                end
            end
            if (ret) void'(pend.pop_front());
            if (acc) begin
                ent_t e;
                e.tag = next_tag; e.rd = rd; e.data = '0; e.done = 0;
                pend.push_back(e);
                m_rv = 1; m_tag = next_tag; m_op = op; m_a = a;
                next_tag = (next_tag + 1) % DEPTH;
            end else if (hs) begin
                m_rv = 0;
            end
            tick();
            if (hs) elig.push_back(hs_tag);
        end
        idle();
    endtask

    task automatic test_errors();
        do_reset();
        bus.resp_valid = 1'b1; bus.resp_tag = 2'd2; bus.resp_data = 32'hDEADBEEF;
        tick();
        bus.resp_valid = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL stray_err got %0b want 1", err); end
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL stray_wb got %0b want 0", bus.wb_valid); end
        tick();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL stray_sticky got %0b want 1", err); end
        do_reset();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rsv_err_clear got %0b want 0", err); end
        bus.req_ready = 1'b1;
        drive_op(2'd3, 5'd7, 32'h1, 32'h2);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rsv_in_ready got %0b want 0", bus.in_ready); end
        tick();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rsv_err got %0b want 1", err); end
        n_cmp++; if (bus.req_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rsv_not_taken got req%0b busy%0b want 0 0", bus.req_valid, busy); end
        tick();
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rsv_held_ready got %0b want 0", bus.in_ready); end
        drop_op();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_op(2'd0, RD_W'(k + 1), $urandom, $urandom);
            tick();
        end
        drop_op();
        bus.req_ready = 1'b0;
        bus.resp_valid = 1'b1; bus.resp_tag = 2'd0; bus.resp_data = 32'h12345678;
        tick();
        bus.resp_valid = 1'b0;
        n_cmp++; if (bus.req_valid !== 1'b1 || bus.wb_valid !== 1'b1 || busy !== 1'b1)
            begin n_bad++; $display("FAIL areset_pre got req%0b wb%0b busy%0b want 1 1 1", bus.req_valid, bus.wb_valid, busy); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (bus.req_valid !== 1'b0) begin n_bad++; $display("FAIL areset_req_valid got %0b want 0", bus.req_valid); end
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL areset_wb_valid got %0b want 0", bus.wb_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL areset_busy got %0b want 0", busy); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        bus.req_ready = 1'b1;
        drive_op(2'd1, 5'd9, 32'h0BADF00D, 32'h1);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL areset_in_ready got %0b want 1", bus.in_ready); end
        tick();
        drop_op();
        n_cmp++; if (bus.req_valid !== 1'b1 || bus.req_tag !== 2'd0)
            begin n_bad++; $display("FAIL areset_tag got v%0b tag%0d want v1 tag0", bus.req_valid, bus.req_tag); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL areset_err_clear got %0b want 0", err); end
        bus.resp_valid = 1'b1; bus.resp_tag = 2'd1; bus.resp_data = 32'h0;
        tick();
        bus.resp_valid = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL areset_stale_resp got %0b want 1", err); end
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_single();
        test_out_of_order();
        test_full();
        test_backpressure();
        test_random();
        test_errors();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/saph_fpu_client.md
Name: saph_fpu_client

Overview:
- Requester end of the FPU port protocol; one instance per shader lane.
- Accepts FP ops (add/mul/div) from the lane's issue stage and drives them onto one FPU port with a slot tag.
- Collects results, which can return out of order because different arithmetic units have different latencies.
- Retires results to the register-file write port strictly in program order.

Parameters:
- DEPTH, 4, completion-buffer slots and maximum ops in flight; power of two, 2..16.
- TAG_W, $clog2(DEPTH), width of the slot tag carried on the FPU port.
- DATA_W, 32, operand/result width (binary32).
- RD_W, 5, destination-register index width.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-low: asserting rst low resets immediately; release is sampled on clk.
- in_valid  in  1  lane presents an op.
- in_ready  out  1  op accepted when in_valid && in_ready at the clk edge.
- in_op  in  2  0=add, 1=mul, 2=div, 3=reserved.
- in_rd  in  RD_W  destination register.
- in_a, in_b  in  DATA_W  operands.
- req_valid  out  1  FPU request valid.
- req_ready  in  1  FPU port accepts the request.
- req_op  out  2  registered copy of in_op.
- req_a, req_b  out  DATA_W  registered operands.
- req_tag  out  TAG_W  slot index.
- resp_valid  in  1  result valid this cycle; no backpressure.
- resp_tag  in  TAG_W  slot that the result belongs to.
- resp_data  in  DATA_W  result.
- wb_valid  out  1  in-order result available.
- wb_ready  in  1  register-file write accepted.
- wb_rd  out  RD_W  destination register of the head slot.
- wb_data  out  DATA_W  result of the head slot.
- busy  out  1  any slot not FREE, or req_valid high.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values: all slots FREE; head=tail=0; count=0; req_valid=0; wb_valid=0; err=0; busy=0; data registers don't-care.
- Slot states:
  - FREE -> WAIT on accept of an op.
  - WAIT -> DONE on resp_valid && resp_tag==slot; resp_data is captured.
  - DONE -> FREE on a wb handshake at head.
- in_ready = (count<DEPTH) && (!req_valid || req_ready) && (in_op!=3).
  - Full: in_ready=0 even if a retire happens the same cycle; no same-cycle bypass.
- Reserved op (in_op==3 with in_valid): never accepted; err set the cycle it is first presented; in_ready stays 0 while it is held.
- Accept:
  - Slot[tail] becomes WAIT and captures in_rd; tail increments modulo DEPTH; count increments.
  - The request register loads op/a/b with tag=tail, and req_valid=1 from the next cycle.
- Request register:
  - Holds stable while req_valid && !req_ready.
  - Clears on req_ready unless a new accept refills it the same cycle (back-to-back issue at 1 op/clk).
- Issue-to-result latency is owned by the FPU. The client makes no assumption beyond "at least 1 cycle after the req handshake".
- Response handling:
  - Response to a slot not in WAIT: ignored and err set.
  - Responses are accepted in any order.
- Write-back:
  - wb_valid = slot[head]==DONE, with wb_rd and wb_data driven from slot[head] registers (no combinational path from resp_*).
  - A result arriving for the head becomes visible the next cycle.
  - On wb_valid && wb_ready: head increments modulo DEPTH and count decrements.
- Simultaneous events:
  - Accept and retire in the same cycle: count unchanged.
  - A response for slot k and a retire of head j≠k in the same cycle are both applied.
- Wrap-around: head and tail are TAG_W-bit modulo counters; full/empty is decided by count (width TAG_W+1), never by pointer compare.
- Reset mid-operation: all state is discarded and req_valid drops immediately; any response arriving after reset release is treated as stray (err).

Decomposition:
- saph_fpu_pkg holds:
  - fpu_op_t enum (ADD=0, MUL=1, DIV=2, RSV=3);
  - slot_state_t enum (FREE, WAIT, DONE);
  - typedef slot_t {state, rd, data}.
- Sub-module saph_fpu_client_rob: the completion buffer (slot array, head/tail/count, wb outputs).
- The top level keeps the request register and the input handshake.

Test Plan:
- Single op: add a=0x3F800000, b=0x40000000, rd=3, req_ready=1; respond tag 0 data 0x40400000 two cycles later -> req_tag=0; wb_valid one cycle after the response with wb_rd=3, wb_data=0x40400000; busy=0 after the wb handshake.
- Out-of-order: issue div (tag0, rd1) then add (tag1, rd2); respond tag1 first, tag0 five cycles later -> wb_valid stays 0 until the tag0 result; then rd1 retires, then rd2 on the next cycle.
- Full: DEPTH=4, 4 ops accepted, no responses -> in_ready=0 with count=4; a 5th in_valid held is not accepted; after one retire it is accepted with tag=0 (wrap).
- Backpressure: req_ready=0 for 3 cycles -> req_op/a/b/tag stable; in_ready=0; no slot leak.
- Stray response: resp_valid with tag=2 while slot 2 is FREE -> err=1, sticky; wb_valid unaffected.
- Async reset: drive rst low between clock edges with 3 ops in flight -> req_valid, wb_valid and busy go 0 without waiting for clk; after release, in_ready=1 and the next accept gets tag 0.
